// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use bubbles, memory stalls, branch flushes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_writes_rd,
  input  logic        id_is_load,
  input  logic        br_taken,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  state,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_STALL  = 2'b01,
    MEM_STALL = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic        lu, ms;

  always_comb begin
    ms = dmem_req & ~dmem_resp;
    lu = id_valid & ex_valid_q & ex_is_load_q & (ex_rd_q != 5'd0) &
         ((id_uses_rs1 & (id_rs1 == ex_rd_q)) | (id_uses_rs2 & (id_rs2 == ex_rd_q)));
  end

  // Outputs depend only on the current inputs and tracker; state is informational
  // because ms, br_taken and lu fully determine the cycle's action.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    state_d     = RUN;
    if (!rst) begin
      if (ms) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        state_d   = MEM_STALL;
      end else if (br_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = RUN;
      end else if (lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = LU_STALL;
      end
    end
  end

  // Shadow of the ID/EX register: only what the load-use check needs.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    if (!stall_ex) begin
      if (bubble_ex || flush_id_ex) begin
        ex_valid_d = 1'b0;
      end else if (!stall_id) begin
        ex_valid_d   = id_valid & id_writes_rd;
        ex_rd_d      = id_rd;
        ex_is_load_d = id_is_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_id};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_id_ex};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: stimulus pushes expected
// responses, a monitor pops and compares them each cycle.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        id_writes_rd = 1'b0, id_is_load = 1'b0;
  logic        br_taken = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
  logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex;
  logic        flush_if_id, flush_id_ex;
  logic [1:0]  state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_writes_rd(id_writes_rd), .id_is_load(id_is_load),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .state(state), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [6:0]  o;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] run_sc = 0, run_fc = 0;
  bit stim_done = 0;

  // o = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if_id, flush_id_ex}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_MS   = 7'b1111000;
  localparam logic [6:0] O_BR   = 7'b0000011;

  task automatic vec(input string nm, input logic r, input logic v,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic wr, input logic ld, input logic br,
                     input logic req, input logic resp,
                     input logic [6:0] eo, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = rd;
    id_writes_rd = wr; id_is_load = ld; br_taken = br;
    dmem_req = req; dmem_resp = resp;
    if (r) begin
      run_sc = 0;
      run_fc = 0;
    end
    e.nm = nm; e.o = eo; e.st = es;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = run_sc; e.fc = run_fc;
`else
    e.sc = 0; e.fc = 0;
`endif
    q.push_back(e);
    run_sc = run_sc + {31'd0, eo[5]};
    run_fc = run_fc + {31'd0, eo[0]};
  endtask

  task automatic idle(input string nm, input logic [6:0] eo, input logic [1:0] es);
    vec(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, es);
  endtask

  // Monitor: outputs are stable 2 time units after the negedge drive.
  initial begin
    exp_t r;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        r = q.pop_front();
        act = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if_id, flush_id_ex};
        checks++;
        if (act !== r.o) begin
          errors++;
          $display("FAIL %s outputs: got %b expected %b", r.nm, act, r.o);
        end
        checks++;
        if (state !== r.st) begin
          errors++;
          $display("FAIL %s state: got %b expected %b", r.nm, state, r.st);
        end
        checks++;
        if (perf_stall_cnt !== r.sc || perf_flush_cnt !== r.fc) begin
          errors++;
          $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   r.nm, perf_stall_cnt, perf_flush_cnt, r.sc, r.fc);
        end
      end
    end
  end

  initial begin
    //   name            rst v  rs1 rs2 u1 u2 rd wr ld br rq rs  outputs  state
    vec("reset_hold",      1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 2'b00);
    vec("lw_x5",           0, 1, 1,  0,  1, 0, 5, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("add_x6_x5_lu",    0, 1, 5,  7,  1, 1, 6, 1, 0, 0, 0, 0, O_LU,   2'b00);
    vec("add_after_bub",   0, 1, 5,  7,  1, 1, 6, 1, 0, 0, 0, 0, O_NONE, 2'b01);
    vec("lw_x0",           0, 1, 1,  0,  1, 0, 0, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("add_x1_x0_x0",    0, 1, 0,  0,  1, 1, 1, 1, 0, 0, 0, 0, O_NONE, 2'b00);
    vec("lw_x5_b",         0, 1, 1,  0,  1, 0, 5, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("addi_x6_x5_lu",   0, 1, 5,  1,  1, 0, 6, 1, 0, 0, 0, 0, O_LU,   2'b00);
    vec("lw_x5_c",         0, 1, 1,  0,  1, 0, 5, 1, 1, 0, 0, 0, O_NONE, 2'b01);
    vec("lui_x5_nolu",     0, 1, 5,  5,  0, 0, 5, 1, 0, 0, 0, 0, O_NONE, 2'b00);
    vec("lw_x7",           0, 1, 1,  0,  1, 0, 7, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("add_rs2_x7_lu",   0, 1, 1,  7,  1, 1, 8, 1, 0, 0, 0, 0, O_LU,   2'b00);
    idle("idle_after_lu2", O_NONE, 2'b01);
    vec("ms_1",            0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, O_MS,   2'b00);
    vec("ms_2",            0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, O_MS,   2'b10);
    vec("ms_3",            0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, O_MS,   2'b10);
    vec("ms_resp",         0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 1, O_NONE, 2'b10);
    idle("after_resp",     O_NONE, 2'b00);
    vec("lw_x5_d",         0, 1, 1,  0,  1, 0, 5, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("lu_and_br",       0, 1, 5,  7,  1, 1, 6, 1, 0, 1, 0, 0, O_BR,   2'b00);
    idle("after_flush",    O_NONE, 2'b00);
    vec("br_during_ms",    0, 0, 0,  0,  0, 0, 0, 0, 0, 1, 1, 0, O_MS,   2'b00);
    vec("br_at_resp",      0, 0, 0,  0,  0, 0, 0, 0, 0, 1, 1, 1, O_BR,   2'b10);
    idle("after_br_ms",    O_NONE, 2'b00);
    vec("lw_x5_e",         0, 1, 1,  0,  1, 0, 5, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("invalid_id_dep",  0, 0, 5,  7,  1, 1, 6, 1, 0, 0, 0, 0, O_NONE, 2'b00);
    vec("ms_pre_rst",      0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, O_MS,   2'b00);
    vec("ms_pre_rst2",     0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, O_MS,   2'b10);
    vec("rst_in_ms",       1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, O_NONE, 2'b00);
    idle("post_rst_ms",    O_NONE, 2'b00);
    vec("lw_x5_f",         0, 1, 1,  0,  1, 0, 5, 1, 1, 0, 0, 0, O_NONE, 2'b00);
    vec("lu_pre_rst",      0, 1, 5,  7,  1, 1, 6, 1, 0, 0, 0, 0, O_LU,   2'b00);
    vec("rst_in_lu",       1, 1, 5,  7,  1, 1, 6, 1, 0, 0, 0, 0, O_NONE, 2'b00);
    vec("post_rst_lu",     0, 1, 5,  7,  1, 1, 6, 1, 0, 0, 0, 0, O_NONE, 2'b00);
    stim_done = 1;
  end

  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule
